// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral
// I/O device model sitting on the far end of a DMA DREQ/DACK handshake.
// Bytes are buffered in a small FIFO. In TX (device to memory) the local
// producer fills the FIFO and the controller drains it with IOR strobes; in
// RX (memory to device) the controller fills it with IOW strobes and the
// local consumer drains it. DEPTH must be a power of two (pointer wrap relies
// on it) and TX_THRESH must lie in 1..DEPTH.
module dma_io_peripheral #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TX_THRESH  = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      dir,
    input  logic                      push_valid,
    input  logic [DATA_WIDTH-1:0]     push_data,
    output logic                      push_ready,
    output logic                      pop_valid,
    output logic [DATA_WIDTH-1:0]     pop_data,
    input  logic                      pop_ready,
    output logic                      dreq,
    input  logic                      dack_n,
    input  logic                      ior_n,
    input  logic                      iow_n,
    input  logic                      eop_n,
    input  logic [DATA_WIDTH-1:0]     db_in,
    output logic [DATA_WIDTH-1:0]     db_out,
    output logic                      db_oe,
    input  logic                      status_clear,
    output logic                      tc,
    output logic                      overrun,
    output logic                      underrun,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH     = CW'(TX_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  dir_q;
    logic                  ior_q;
    logic                  iow_q;
    logic [DATA_WIDTH-1:0] cap_q;

    logic                  ior_act;
    logic                  iow_act;
    logic                  empty;
    logic                  full;
    logic                  ior_trail;
    logic                  iow_trail;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  dma_rd;
    logic                  dma_wr;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CW-1:0]         count_next;
    logic                  tc_next;
    logic                  dir_next;
    logic                  dreq_next;

    // A strobe only counts while the controller is acknowledging us.
    assign ior_act = ~ior_n & ~dack_n;
    assign iow_act = ~iow_n & ~dack_n;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Local handshakes are gated by the latched direction, so the local side
    // and the DMA side never compete for the same pointer.
    assign push_ready = dir_q & ~full;
    assign pop_valid  = ~dir_q & ~empty;
    assign pop_data   = mem[rd_ptr];

    // Bus drive follows the qualified IOR strobe directly; an empty FIFO
    // reads as all-ones so the controller sees a recognisable idle pattern.
    assign db_oe  = dir_q & ior_act;
    assign db_out = db_oe ? (empty ? '1 : mem[rd_ptr]) : '0;

    // Transfers commit on the trailing edge of the strobe.
    assign ior_trail = dir_q & ior_q & ~ior_act;
    assign iow_trail = ~dir_q & iow_q & ~iow_act;

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;
    assign dma_rd    = ior_trail & ~empty;
    assign dma_wr    = iow_trail & ~full;

    assign fifo_wr = push_fire | dma_wr;
    assign fifo_rd = dma_rd | pop_fire;
    assign wr_data = dir_q ? push_data : cap_q;

    // Set wins over a same-cycle clear.
    assign tc_next = (~eop_n & ~dack_n) | (tc & ~status_clear);

    // Direction may only change while idle: nothing buffered, no DACK.
    assign dir_next = (empty & dack_n) ? dir : dir_q;

    // Next occupancy and the request decision derived from it.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        count_next = count;
        dreq_next  = 1'b0;
        case ({fifo_wr, fifo_rd})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        if (dir_next != dir_q || tc_next) begin
            dreq_next = 1'b0;
        end else if (dir_q) begin
            dreq_next = (count_next >= THRESH);
        end else begin
            dreq_next = (count_next < FULL_COUNT);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        // NOTE: storage has no reset; the pointers define validity, so stale contents are never observed.
        if (fifo_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Control state: pointers, occupancy, strobe history, status and DREQ.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dir_q    <= 1'b1;
            ior_q    <= 1'b0;
            iow_q    <= 1'b0;
            cap_q    <= '0;
            tc       <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            dreq     <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            dir_q <= dir_next;
            ior_q <= ior_act & dir_q;
            iow_q <= iow_act & ~dir_q;
            if (iow_act & ~dir_q) begin
                cap_q <= db_in;
            end
            tc       <= tc_next;
            overrun  <= (iow_trail & full) | (overrun & ~status_clear);
            underrun <= (ior_trail & empty) | (underrun & ~status_clear);
            dreq     <= dreq_next;
        end
    end

endmodule

// File: doc/dma_io_peripheral.md
Name: dma_io_peripheral

Overview:
- Synchronous I/O-device model for the far end of the DMA controller's DREQ/DACK handshake.
- Buffers bytes in an internal FIFO and raises DREQ when it needs service.
- Answers the controller's IOR_N/IOW_N strobes during DACK: drives data for I/O-to-memory (write) transfers and captures data for memory-to-I/O (read) transfers.
- Instantiated in the bench and system alongside the dma top, sharing busInterface clock and reset.

Parameters:
- DATA_WIDTH, 8, width of the data bus and FIFO entries.
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- TX_THRESH, 1, minimum FIFO occupancy before DREQ is raised in TX direction; range 1..DEPTH.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- dir  in  1  requested direction: 1 = TX (device to memory, serviced by IOR_N), 0 = RX (memory to device, serviced by IOW_N).
- push_valid  in  1  local producer byte valid (TX).
- push_data  in  DATA_WIDTH  local producer byte.
- push_ready  out  1  FIFO can accept a byte (dir_q=1 and not full).
- pop_valid  out  1  FIFO holds a byte for the local consumer (dir_q=0 and not empty).
- pop_data  out  DATA_WIDTH  FIFO head byte.
- pop_ready  in  1  local consumer accepts the head byte.
- dreq  out  1  DMA request, registered.
- dack_n  in  1  DMA acknowledge, active low.
- ior_n  in  1  I/O read strobe, active low.
- iow_n  in  1  I/O write strobe, active low.
- eop_n  in  1  end of process from the controller, active low.
- db_in  in  DATA_WIDTH  data bus into the device.
- db_out  out  DATA_WIDTH  data driven onto the bus.
- db_oe  out  1  bus drive enable.
- status_clear  in  1  single-cycle pulse; clears tc, overrun and underrun.
- tc  out  1  sticky: terminal count seen.
- overrun  out  1  sticky: IOW arrived while the FIFO was full.
- underrun  out  1  sticky: IOR arrived while the FIFO was empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - Outputs: dreq=0, db_oe=0, db_out=0, tc=0, overrun=0, underrun=0, count=0.
  - Internal: dir_q=1, FIFO pointers 0.
  - RESET mid-transfer aborts the transfer and drops all pending data.
- Direction latch: dir_q<=dir only when count==0 and dack_n==1; otherwise dir_q holds.
- Local side:
  - Push when push_valid && push_ready.
  - Pop when pop_valid && pop_ready.
  - Local handshakes are gated by dir_q, so at most one local operation and one DMA-side operation occur per cycle.
- Strobe qualification:
  - A strobe is "active" when it is low and dack_n==0 in the same cycle.
  - Registered copies ior_q and iow_q hold the previous-cycle active state.
- TX service (dir_q=1):
  - While IOR is active: db_oe=1 combinationally, db_out=FIFO head, or all-ones if empty.
  - On the first cycle with ior_q=1 and IOR no longer active (trailing edge):
    - Pop one entry if not empty.
    - If empty, set underrun and leave pointers unchanged.
- RX service (dir_q=0):
  - While IOW is active, register db_in into cap_q every cycle.
  - On the trailing edge (iow_q=1 and IOW no longer active):
    - Write cap_q if not full.
    - If full, set overrun and drop the byte.
- Strobes in the wrong direction are ignored: db_oe stays 0 and no FIFO change occurs.
- Simultaneous push and DMA pop (TX), or DMA write and local pop (RX): both take effect and count is unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH inclusive.
- DREQ:
  - Next-state condition:
    - TX: count_next >= TX_THRESH && !tc.
    - RX: count_next < DEPTH && !tc.
  - Registered, so dreq falls in the cycle after the trailing edge that empties (TX) or fills (RX) the FIFO.
  - dreq is also 0 during the cycle dir_q changes.
- Terminal count:
  - eop_n==0 while dack_n==0 sets tc on the next edge; the in-flight strobe still completes.
  - tc forces dreq=0 until status_clear.
  - status_clear and a same-cycle set event: set wins.
- Demand mode is supported: dreq stays high across back-to-back strobes while the condition holds.

Test Plan:
- Reset with dir=1, then push 0x11, 0x22, 0x33 -> count=3 and dreq=1 one cycle after the first push.
- Three IOR pulses under DACK -> db_out shows 0x11, 0x22, 0x33 with db_oe=1 only during the strobes; dreq=0 the cycle after the third trailing edge; count=0.
- dir=0, DEPTH=16: 16 IOW pulses with db_in=0x00..0x0F -> dreq falls after the 16th. A 17th IOW with db_in=0xAA -> overrun=1, count=16, and pop yields 0x00..0x0F.
- IOR with an empty FIFO in TX -> db_out=0xFF, underrun=1, count stays 0. status_clear -> underrun=0.
- eop_n low during the 2nd of 4 queued IOR transfers -> that byte still pops, tc=1, dreq=0 with count=2. status_clear -> dreq=1 next cycle.
- Local push coinciding with an IOR trailing edge at count=5 -> count stays 5. dir toggled while count!=0 -> dir_q unchanged until the FIFO drains.
